game_flow_ctrl: RTL and testbench

- Frame-rate game sequencer for the bird datapath.
- Owns bird height and vertical velocity; applies gravity and flap impulses on each frame tick.
- Samples the external dead detector (height in, is_dead out) and walks IDLE -> PLAY -> DYING -> OVER.
- Keeps the pipe-pass score; sits between the button debouncer/frame timer and the renderer/dead detector.

---
 rtl/game_pkg.sv | 17 +
 rtl/rise_detect.sv | 22 ++
 rtl/game_flow_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_game_flow_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared constants for the bird game: FSM state codes, datapath widths and
// screen geometry used by both the flow controller and the dead detector.
package game_pkg;

  localparam int HEIGHT_W = 9;
  localparam int VEL_W    = 6;
  localparam int SCORE_W  = 8;

  localparam int SCREEN_H = 480;
  localparam int START_Y  = SCREEN_H / 2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PLAY  = 2'd1;
  localparam logic [1:0] ST_DYING = 2'd2;
  localparam logic [1:0] ST_OVER  = 2'd3;

endpackage

// File: rtl/rise_detect.sv
// Registered rising-edge detector: pulses for the cycle in which d_i is high
// and its value from the previous cycle was low.
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic rise_o
);

  logic prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= d_i;
    end
  end

  assign rise_o = d_i & ~prev_q;

endmodule

// File: rtl/game_flow_ctrl.sv
// Frame-rate game sequencer: owns bird height/velocity, applies gravity and
// flaps per frame tick, walks IDLE -> PLAY -> DYING -> OVER and keeps score.
module game_flow_ctrl #(
  parameter int HEIGHT_W     = game_pkg::HEIGHT_W,
  parameter int VEL_W        = game_pkg::VEL_W,
  parameter int START_HEIGHT = game_pkg::START_Y,
  parameter int FLAP_VEL     = -6,
  parameter int GRAVITY      = 1,
  parameter int MAX_FALL_VEL = 7,
  parameter int DEAD_HOLD    = 60,
  parameter int SCORE_W      = game_pkg::SCORE_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                frame_tick_i,
  input  logic                flap_btn_i,
  input  logic                is_dead_i,
  input  logic                pipe_passed_i,
  output logic [HEIGHT_W-1:0] height_o,
  output logic [VEL_W-1:0]    velocity_o,
  output logic [1:0]          state_o,
  output logic [SCORE_W-1:0]  score_o,
  output logic                game_over_o
);

  import game_pkg::*;

  localparam int CNT_W = $clog2(DEAD_HOLD) + 1;
  localparam logic signed [VEL_W-1:0] FLAP_V    = VEL_W'(FLAP_VEL);
  localparam logic signed [VEL_W-1:0] FALL_V    = VEL_W'(MAX_FALL_VEL);
  localparam logic signed [VEL_W:0]   GRAV_X    = (VEL_W+1)'(GRAVITY);
  localparam logic signed [VEL_W:0]   FALL_X    = (VEL_W+1)'(MAX_FALL_VEL);
  localparam logic [HEIGHT_W-1:0]     START_H   = HEIGHT_W'(START_HEIGHT);
  localparam logic [CNT_W-1:0]        HOLD_LAST = CNT_W'(DEAD_HOLD - 1);

  logic [1:0]              state_q, state_d;
  logic [HEIGHT_W-1:0]     height_q, height_d;
  logic signed [VEL_W-1:0] vel_q, vel_d;
  logic [SCORE_W-1:0]      score_q, score_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    flap_pend_q, flap_pend_d;
  logic                    game_over_q;

  logic                    flap_rise_s;
  logic signed [VEL_W:0]   vel_inc_s;
  logic signed [VEL_W-1:0] v_next_s;
  logic signed [VEL_W-1:0] step_s;
  logic [HEIGHT_W+1:0]     h_sum_s;
  logic [HEIGHT_W-1:0]     h_new_s;
  logic [CNT_W-1:0]        cnt_inc_s;

  // The two extra sum bits carry the sign and the overflow past the screen bottom.
  function automatic logic [HEIGHT_W-1:0] clamp_height(input logic [HEIGHT_W+1:0] s);
    if (s[HEIGHT_W+1]) begin
      return '0;
    end else if (s[HEIGHT_W]) begin
      return '1;
    end else begin
      return s[HEIGHT_W-1:0];
    end
  endfunction

  rise_detect u_flap_rise (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (flap_btn_i),
    .rise_o (flap_rise_s)
  );

  // Candidate physics step; DYING always falls at terminal velocity.
  always_comb begin
    vel_inc_s = {vel_q[VEL_W-1], vel_q} + GRAV_X;
    if (flap_pend_q) begin
      v_next_s = FLAP_V;
    end else if (vel_inc_s > FALL_X) begin
      v_next_s = FALL_V;
    end else begin
      v_next_s = vel_inc_s[VEL_W-1:0];
    end
    step_s  = (state_q == ST_DYING) ? FALL_V : v_next_s;
    h_sum_s = {2'b00, height_q} + {{(HEIGHT_W+2-VEL_W){step_s[VEL_W-1]}}, step_s};
    h_new_s = clamp_height(h_sum_s);
  end

  always_comb begin
    state_d     = state_q;
    height_d    = height_q;
    vel_d       = vel_q;
    score_d     = score_q;
    cnt_d       = cnt_q;
    flap_pend_d = flap_pend_q;
    cnt_inc_s   = cnt_q + CNT_W'(1);
    case (state_q)
      ST_IDLE: begin
        height_d = START_H;
        vel_d    = '0;
        if (flap_rise_s) begin
          state_d     = ST_PLAY;
          score_d     = '0;
          flap_pend_d = 1'b1;
        end else begin
          flap_pend_d = 1'b0;
        end
      end
      ST_PLAY: begin
        if (pipe_passed_i && (score_q != '1)) begin
          score_d = score_q + SCORE_W'(1);
        end else begin
          score_d = score_q;
        end
        // A new edge outranks consumption, so an edge on a tick waits for the next tick.
        if (flap_rise_s) begin
          flap_pend_d = 1'b1;
        end else if (frame_tick_i) begin
          flap_pend_d = 1'b0;
        end else begin
          flap_pend_d = flap_pend_q;
        end
        if (frame_tick_i && is_dead_i) begin
          state_d = ST_DYING;
          cnt_d   = '0;
        end else if (frame_tick_i) begin
          height_d = h_new_s;
          vel_d    = v_next_s;
        end else begin
          height_d = height_q;
        end
      end
      ST_DYING: begin
        flap_pend_d = 1'b0;
        if (frame_tick_i) begin
          height_d = h_new_s;
          cnt_d    = cnt_inc_s;
          if (cnt_inc_s == HOLD_LAST) begin
            state_d = ST_OVER;
          end else begin
            state_d = ST_DYING;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_OVER: begin
        flap_pend_d = 1'b0;
        if (flap_rise_s) begin
          state_d  = ST_IDLE;
          height_d = START_H;
          vel_d    = '0;
        end else begin
          state_d = ST_OVER;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      height_q    <= START_H;
      vel_q       <= '0;
      score_q     <= '0;
      cnt_q       <= '0;
      flap_pend_q <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      height_q    <= height_d;
      vel_q       <= vel_d;
      score_q     <= score_d;
      cnt_q       <= cnt_d;
      flap_pend_q <= flap_pend_d;
      game_over_q <= (state_d == ST_OVER);
    end
  end

  assign height_o    = height_q;
  assign velocity_o  = vel_q;
  assign state_o     = state_q;
  assign score_o     = score_q;
  assign game_over_o = game_over_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl: a default instance plus a SCORE_W=2
// instance driven by the same stimulus to show score saturation.
module tb_game_flow_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, frame_tick, flap_btn, is_dead, pipe_passed;
  logic [8:0] height, height2;
  logic [5:0] velocity, velocity2;
  logic [1:0] state, state2;
  logic [7:0] score;
  logic [1:0] score2;
  logic       game_over, game_over2;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  game_flow_ctrl dut (
    .clk(clk), .rst_n(rst_n), .frame_tick_i(frame_tick), .flap_btn_i(flap_btn),
    .is_dead_i(is_dead), .pipe_passed_i(pipe_passed), .height_o(height),
    .velocity_o(velocity), .state_o(state), .score_o(score), .game_over_o(game_over)
  );

  game_flow_ctrl #(.SCORE_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .frame_tick_i(frame_tick), .flap_btn_i(flap_btn),
    .is_dead_i(is_dead), .pipe_passed_i(pipe_passed), .height_o(height2),
    .velocity_o(velocity2), .state_o(state2), .score_o(score2), .game_over_o(game_over2)
  );

  task automatic tick();
    @(negedge clk); frame_tick = 1'b1;
    @(negedge clk); frame_tick = 1'b0;
  endtask

  task automatic press();
    @(negedge clk); flap_btn = 1'b1;
    @(negedge clk); flap_btn = 1'b0;
  endtask

  task automatic pipe();
    @(negedge clk); pipe_passed = 1'b1;
    @(negedge clk); pipe_passed = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++; if (state !== 2'd0) begin tests_failed++; $display("FAIL rst_state: got %0d expected 0", state); end
    tests_run++; if (height !== 9'd240) begin tests_failed++; $display("FAIL rst_height: got %0d expected 240", height); end
    tests_run++; if (velocity !== 6'd0) begin tests_failed++; $display("FAIL rst_vel: got %0d expected 0", $signed(velocity)); end
    tests_run++; if (score !== 8'd0) begin tests_failed++; $display("FAIL rst_score: got %0d expected 0", score); end
    tests_run++; if (game_over !== 1'b0) begin tests_failed++; $display("FAIL rst_game_over: got %0d expected 0", game_over); end
    rst_n = 1'b1;
    repeat (5) tick();
    tests_run++; if (state !== 2'd0) begin tests_failed++; $display("FAIL idle_state: got %0d expected 0", state); end
    tests_run++; if (height !== 9'd240) begin tests_failed++; $display("FAIL idle_height: got %0d expected 240", height); end
    tests_run++; if (velocity !== 6'd0) begin tests_failed++; $display("FAIL idle_vel: got %0d expected 0", $signed(velocity)); end
    tests_run++; if (score !== 8'd0) begin tests_failed++; $display("FAIL idle_score: got %0d expected 0", score); end
  endtask

  task automatic test_start_gravity();
    int eh[4] = '{234, 229, 225, 222};
    int ev[4] = '{-6, -5, -4, -3};
    press();
    tests_run++; if (state !== 2'd1) begin tests_failed++; $display("FAIL start_state: got %0d expected 1", state); end
    for (int i = 0; i < 4; i++) begin
      tick();
      tests_run++; if (height !== 9'(eh[i])) begin tests_failed++; $display("FAIL grav_h[%0d]: got %0d expected %0d", i, height, eh[i]); end
      tests_run++; if (velocity !== 6'(ev[i])) begin tests_failed++; $display("FAIL grav_v[%0d]: got %0d expected %0d", i, $signed(velocity), ev[i]); end
    end
    repeat (3) @(negedge clk);
    tests_run++; if (height !== 9'd222) begin tests_failed++; $display("FAIL hold_h: got %0d expected 222", height); end
    tests_run++; if (velocity !== 6'(-3)) begin tests_failed++; $display("FAIL hold_v: got %0d expected -3", $signed(velocity)); end
  endtask

  task automatic test_clamp();
    int eh[12] = '{220, 219, 219, 220, 222, 225, 229, 234, 240, 247, 254, 261};
    int ev[12] = '{-2, -1, 0, 1, 2, 3, 4, 5, 6, 7, 7, 7};
    for (int i = 0; i < 12; i++) begin
      tick();
      tests_run++; if (height !== 9'(eh[i])) begin tests_failed++; $display("FAIL clamp_h[%0d]: got %0d expected %0d", i, height, eh[i]); end
      tests_run++; if (velocity !== 6'(ev[i])) begin tests_failed++; $display("FAIL clamp_v[%0d]: got %0d expected %0d", i, $signed(velocity), ev[i]); end
    end
  endtask

  task automatic test_flap_collapse();
    repeat (3) press();
    tick();
    tests_run++; if (velocity !== 6'(-6)) begin tests_failed++; $display("FAIL collapse_v0: got %0d expected -6", $signed(velocity)); end
    tests_run++; if (height !== 9'd255) begin tests_failed++; $display("FAIL collapse_h0: got %0d expected 255", height); end
    tick();
    tests_run++; if (velocity !== 6'(-5)) begin tests_failed++; $display("FAIL collapse_v1: got %0d expected -5", $signed(velocity)); end
    tests_run++; if (height !== 9'd250) begin tests_failed++; $display("FAIL collapse_h1: got %0d expected 250", height); end
    @(negedge clk); frame_tick = 1'b1; flap_btn = 1'b1;
    @(negedge clk); frame_tick = 1'b0; flap_btn = 1'b0;
    tests_run++; if (velocity !== 6'(-4)) begin tests_failed++; $display("FAIL same_cycle_v: got %0d expected -4", $signed(velocity)); end
    tests_run++; if (height !== 9'd246) begin tests_failed++; $display("FAIL same_cycle_h: got %0d expected 246", height); end
    tick();
    tests_run++; if (velocity !== 6'(-6)) begin tests_failed++; $display("FAIL deferred_v: got %0d expected -6", $signed(velocity)); end
    tests_run++; if (height !== 9'd240) begin tests_failed++; $display("FAIL deferred_h: got %0d expected 240", height); end
    tick();
    tests_run++; if (velocity !== 6'(-5)) begin tests_failed++; $display("FAIL after_v: got %0d expected -5", $signed(velocity)); end
    tests_run++; if (height !== 9'd235) begin tests_failed++; $display("FAIL after_h: got %0d expected 235", height); end
  endtask

  task automatic test_top_clamp();
    int exp_h;
    for (int k = 1; k <= 41; k++) begin
      press();
      tick();
      exp_h = 235 - 6 * k;
      if (exp_h < 0) exp_h = 0;
      tests_run++; if (height !== 9'(exp_h)) begin tests_failed++; $display("FAIL top_h[%0d]: got %0d expected %0d", k, height, exp_h); end
      tests_run++; if (velocity !== 6'(-6)) begin tests_failed++; $display("FAIL top_v[%0d]: got %0d expected -6", k, $signed(velocity)); end
    end
  endtask

  task automatic test_death_score();
    int eh[13] = '{0, 0, 0, 0, 0, 0, 1, 3, 6, 10, 15, 21, 28};
    int ev[13] = '{-5, -4, -3, -2, -1, 0, 1, 2, 3, 4, 5, 6, 7};
    repeat (3) pipe();
    tests_run++; if (score !== 8'd3) begin tests_failed++; $display("FAIL score3: got %0d expected 3", score); end
    for (int i = 0; i < 13; i++) begin
      tick();
      tests_run++; if (height !== 9'(eh[i])) begin tests_failed++; $display("FAIL fall_h[%0d]: got %0d expected %0d", i, height, eh[i]); end
      tests_run++; if (velocity !== 6'(ev[i])) begin tests_failed++; $display("FAIL fall_v[%0d]: got %0d expected %0d", i, $signed(velocity), ev[i]); end
    end
    repeat (64) tick();
    tests_run++; if (height !== 9'd476) begin tests_failed++; $display("FAIL pre_death_h: got %0d expected 476", height); end
    @(negedge clk); frame_tick = 1'b1; is_dead = 1'b1; pipe_passed = 1'b1;
    @(negedge clk); frame_tick = 1'b0; is_dead = 1'b0; pipe_passed = 1'b0;
    tests_run++; if (state !== 2'd2) begin tests_failed++; $display("FAIL death_state: got %0d expected 2", state); end
    tests_run++; if (height !== 9'd476) begin tests_failed++; $display("FAIL death_h: got %0d expected 476", height); end
    tests_run++; if (score !== 8'd4) begin tests_failed++; $display("FAIL death_score: got %0d expected 4", score); end
    tests_run++; if (score2 !== 2'd3) begin tests_failed++; $display("FAIL sat_score2: got %0d expected 3", score2); end
    pipe();
    press();
    tests_run++; if (score !== 8'd4) begin tests_failed++; $display("FAIL dying_score: got %0d expected 4", score); end
    tests_run++; if (state !== 2'd2) begin tests_failed++; $display("FAIL dying_flap: got %0d expected 2", state); end
    repeat (58) tick();
    tests_run++; if (state !== 2'd2) begin tests_failed++; $display("FAIL dying58_state: got %0d expected 2", state); end
    tests_run++; if (height !== 9'd511) begin tests_failed++; $display("FAIL dying_sat_h: got %0d expected 511", height); end
    tests_run++; if (game_over !== 1'b0) begin tests_failed++; $display("FAIL dying_go: got %0d expected 0", game_over); end
    tick();
    tests_run++; if (state !== 2'd3) begin tests_failed++; $display("FAIL over_state: got %0d expected 3", state); end
    tests_run++; if (game_over !== 1'b1) begin tests_failed++; $display("FAIL over_go: got %0d expected 1", game_over); end
    pipe();
    tick();
    tests_run++; if (score !== 8'd4) begin tests_failed++; $display("FAIL over_score: got %0d expected 4", score); end
    tests_run++; if (height !== 9'd511) begin tests_failed++; $display("FAIL over_h: got %0d expected 511", height); end
    press();
    tests_run++; if (state !== 2'd0) begin tests_failed++; $display("FAIL restart_state: got %0d expected 0", state); end
    tests_run++; if (height !== 9'd240) begin tests_failed++; $display("FAIL restart_h: got %0d expected 240", height); end
    tests_run++; if (velocity !== 6'd0) begin tests_failed++; $display("FAIL restart_v: got %0d expected 0", $signed(velocity)); end
    tests_run++; if (game_over !== 1'b0) begin tests_failed++; $display("FAIL restart_go: got %0d expected 0", game_over); end
    pipe();
    tests_run++; if (score !== 8'd4) begin tests_failed++; $display("FAIL idle_keep_score: got %0d expected 4", score); end
    press();
    tests_run++; if (state !== 2'd1) begin tests_failed++; $display("FAIL new_game_state: got %0d expected 1", state); end
    tests_run++; if (score !== 8'd0) begin tests_failed++; $display("FAIL new_game_score: got %0d expected 0", score); end
    tick();
    tests_run++; if (velocity !== 6'(-6)) begin tests_failed++; $display("FAIL new_game_v: got %0d expected -6", $signed(velocity)); end
    tests_run++; if (height !== 9'd234) begin tests_failed++; $display("FAIL new_game_h: got %0d expected 234", height); end
  endtask

  task automatic test_reset_midgame();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests_run++; if (state !== 2'd0) begin tests_failed++; $display("FAIL mid_rst_state: got %0d expected 0", state); end
    tests_run++; if (height !== 9'd240) begin tests_failed++; $display("FAIL mid_rst_h: got %0d expected 240", height); end
    tests_run++; if (velocity !== 6'd0) begin tests_failed++; $display("FAIL mid_rst_v: got %0d expected 0", $signed(velocity)); end
    @(negedge clk); rst_n = 1'b1;
    tick();
    tests_run++; if (height !== 9'd240) begin tests_failed++; $display("FAIL post_rst_h: got %0d expected 240", height); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; frame_tick = 1'b0; flap_btn = 1'b0; is_dead = 1'b0; pipe_passed = 1'b0;
    test_reset();
    test_start_gravity();
    test_clamp();
    test_flap_collapse();
    test_top_clamp();
    test_death_score();
    test_reset_midgame();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
